// File: rtl/sar_pkg.sv
// Shared types and default sizing for the SAR conversion sequencer.
// Holds the FSM state encoding and the {init, samp, comp, logi} phase vector.
package sar_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int BIT_W_DEF    = 4;
  localparam int MAX_BITS_DEF = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    SAMP = 3'd2,
    COMP = 3'd3,
    LOGI = 3'd4,
    DONE = 3'd5
  } state_t;

  typedef struct packed {
    logic init;
    logic samp;
    logic comp;
    logic logi;
  } phase_t;

  localparam phase_t PH_NONE = 4'b0000;
  localparam phase_t PH_INIT = 4'b1000;
  localparam phase_t PH_SAMP = 4'b0100;
  localparam phase_t PH_COMP = 4'b0010;
  localparam phase_t PH_LOGI = 4'b0001;

endpackage

// File: rtl/sar_phase_cnt.sv
// Loadable down-counter with a zero flag, shared by the sample and compare phases.
// Saturates at zero, so a full-scale load never wraps early.
module sar_phase_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_srst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // phase length counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_srst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sar_seqgen.sv
// SAR conversion timing sequencer: one start trigger becomes init, sample,
// then nbits x (compare, logic) strobes, all registered.
module sar_seqgen
  import sar_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int BIT_W    = BIT_W_DEF,
  parameter int MAX_BITS = MAX_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic [CNT_W-1:0] cfg_samp_len,
  input  logic [CNT_W-1:0] cfg_comp_len,
  input  logic [BIT_W-1:0] cfg_nbits,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_comp,
  output logic             seq_logi,
  output logic [BIT_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  phase_t           r_phase;
  logic             r_busy;
  logic             r_done;
  logic [BIT_W-1:0] r_bit_idx;
  logic [CNT_W-1:0] r_samp_len;
  logic [CNT_W-1:0] r_comp_len;
  logic [BIT_W-1:0] r_nbits;

  logic [CNT_W-1:0] w_samp_eff;
  logic [CNT_W-1:0] w_comp_eff;
  logic [BIT_W-1:0] w_nbits_eff;
  logic             w_go_init;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_cnt_val;

  function automatic logic [CNT_W-1:0] len_eff(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

  assign w_samp_eff = len_eff(cfg_samp_len);
  assign w_comp_eff = len_eff(cfg_comp_len);

  // effective bit count: 0 -> 1, above MAX_BITS -> MAX_BITS
  always_comb begin
    if (cfg_nbits == '0) begin
      w_nbits_eff = BIT_W'(1);
    end else if (cfg_nbits > BIT_W'(MAX_BITS)) begin
      w_nbits_eff = BIT_W'(MAX_BITS);
    end else begin
      w_nbits_eff = cfg_nbits;
    end
  end

  // conversion launch from IDLE, or straight out of DONE
  always_comb begin
    w_go_init = 1'b0;
    case (r_state)
      IDLE:    w_go_init = start;
      DONE:    w_go_init = cont | start;
      default: w_go_init = 1'b0;
    endcase
  end

  // phase counter control; lengths come from the latched config
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_cnt_val  = '0;
    case (r_state)
      INIT: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = r_samp_len - CNT_W'(1);
      end
      SAMP: begin
        if (w_cnt_zero) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = r_comp_len - CNT_W'(1);
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      COMP: w_cnt_dec = 1'b1;
      LOGI: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = r_comp_len - CNT_W'(1);
      end
      default: w_cnt_load = 1'b0;
    endcase
  end

  sar_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_srst     (abort),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // sequencer FSM; outputs registered with the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_phase    <= PH_NONE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bit_idx  <= '0;
      r_samp_len <= '0;
      r_comp_len <= '0;
      r_nbits    <= '0;
    end else if (abort) begin
      r_state   <= IDLE;
      r_phase   <= PH_NONE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bit_idx <= '0;
    end else if (w_go_init) begin
      r_state    <= INIT;
      r_phase    <= PH_INIT;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_bit_idx  <= '0;
      r_samp_len <= w_samp_eff;
      r_comp_len <= w_comp_eff;
      r_nbits    <= w_nbits_eff;
    end else begin
      case (r_state)
        IDLE: begin
          r_phase <= PH_NONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        INIT: begin
          r_state   <= SAMP;
          r_phase   <= PH_SAMP;
          r_bit_idx <= r_nbits - BIT_W'(1);
        end
        SAMP: begin
          if (w_cnt_zero) begin
            r_state <= COMP;
            r_phase <= PH_COMP;
          end
        end
        COMP: begin
          if (w_cnt_zero) begin
            r_state <= LOGI;
            r_phase <= PH_LOGI;
          end
        end
        LOGI: begin
          if (r_bit_idx != '0) begin
            r_state   <= COMP;
            r_phase   <= PH_COMP;
            r_bit_idx <= r_bit_idx - BIT_W'(1);
          end else begin
            r_state <= DONE;
            r_phase <= PH_NONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_phase   <= PH_NONE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_bit_idx <= '0;
        end
      endcase
    end
  end

  assign seq_init = r_phase.init;
  assign seq_samp = r_phase.samp;
  assign seq_comp = r_phase.comp;
  assign seq_logi = r_phase.logi;
  assign bit_idx  = r_bit_idx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_sar_seqgen.sv
// Directed bench for sar_seqgen: table of configurations with hand-computed
// phase counts, plus cycle-exact sequences for abort, continuous mode and reset.
module tb_sar_seqgen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] cfg_samp_len = 8'd0;
  logic [7:0] cfg_comp_len = 8'd0;
  logic [3:0] cfg_nbits = 4'd0;
  logic       seq_init, seq_samp, seq_comp, seq_logi, busy, done;
  logic [3:0] bit_idx;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int samp_len;
    int comp_len;
    int nbits;
    int t_done;
    int n_samp;
    int n_comp;
    int n_logi;
    int n_busy;
    int first_bit;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  sar_seqgen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cont         (cont),
    .cfg_samp_len (cfg_samp_len),
    .cfg_comp_len (cfg_comp_len),
    .cfg_nbits    (cfg_nbits),
    .seq_init     (seq_init),
    .seq_samp     (seq_samp),
    .seq_comp     (seq_comp),
    .seq_logi     (seq_logi),
    .bit_idx      (bit_idx),
    .busy         (busy),
    .done         (done)
  );

  // phase strobes must be one-hot or all zero in every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if ($countones({seq_init, seq_samp, seq_comp, seq_logi}) > 1) begin
        errors++;
        $display("FAIL onehot0 at %0t: phases %b required at most one set", $time,
                 {seq_init, seq_samp, seq_comp, seq_logi});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs_now();
    return {seq_init, seq_samp, seq_comp, seq_logi, busy, done,
            (seq_comp | seq_logi) ? bit_idx : 4'd0};
  endfunction

  // {init,samp,comp,logi,busy,done,bit_idx} for samp=3 comp=2 nbits=4
  function automatic logic [9:0] exp_basic(input int c);
    case (c)
      1:       return {4'b1000, 2'b10, 4'd0};
      2, 3, 4: return {4'b0100, 2'b10, 4'd0};
      5, 6:    return {4'b0010, 2'b10, 4'd3};
      7:       return {4'b0001, 2'b10, 4'd3};
      8, 9:    return {4'b0010, 2'b10, 4'd2};
      10:      return {4'b0001, 2'b10, 4'd2};
      11, 12:  return {4'b0010, 2'b10, 4'd1};
      13:      return {4'b0001, 2'b10, 4'd1};
      14, 15:  return {4'b0010, 2'b10, 4'd0};
      16:      return {4'b0001, 2'b10, 4'd0};
      17:      return {4'b0000, 2'b01, 4'd0};
      default: return 10'd0;
    endcase
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic set_basic();
    cfg_samp_len = 8'd3;
    cfg_comp_len = 8'd2;
    cfg_nbits    = 4'd4;
    cont         = 1'b0;
  endtask

  task automatic run_basic(input string tag, input bit inject);
    logic [9:0] act;
    logic [9:0] exp;
    set_basic();
    pulse_start();
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      act = outs_now();
      exp = exp_basic(c);
      vectors++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b, expected %b", tag, c, act, exp);
      end
      start = (inject && (c == 3 || c == 7)) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic measure(input int budget, output int t_done, output int n_samp,
                         output int n_comp, output int n_logi, output int n_busy,
                         output int first_bit);
    t_done = -1; n_samp = 0; n_comp = 0; n_logi = 0; n_busy = 0; first_bit = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      n_samp += int'(seq_samp);
      n_comp += int'(seq_comp);
      n_logi += int'(seq_logi);
      n_busy += int'(busy);
      if (seq_logi && first_bit < 0) first_bit = int'(bit_idx);
      if (done) begin
        t_done = c;
        break;
      end
    end
  endtask

  initial begin
    int t_done, n_samp, n_comp, n_logi, n_busy, first_bit;
    logic [31:0] imask, dmask;
    int seen;

    vecs[0] = '{3,   2,   4,  17,  3,   8,  4,  16,  3};
    vecs[1] = '{0,   0,   0,   5,  1,   1,  1,   4,  0};
    vecs[2] = '{1,   1,   2,   7,  1,   2,  2,   6,  1};
    vecs[3] = '{5,   0,   1,   9,  5,   1,  1,   8,  0};
    vecs[4] = '{0,   3,  15,  51,  1,  36, 12,  50, 11};
    vecs[5] = '{255, 255, 1, 513, 255, 255,  1, 512,  0};
    vecs[6] = '{2,   1,  12,  28,  2,  12, 12,  27, 11};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outs", int'(outs_now()), 0);
    check("reset_bit_idx", int'(bit_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", int'(outs_now()), 0);

    run_basic("basic", 1'b0);

    for (int i = 0; i < 7; i++) begin
      cfg_samp_len = 8'(vecs[i].samp_len);
      cfg_comp_len = 8'(vecs[i].comp_len);
      cfg_nbits    = 4'(vecs[i].nbits);
      pulse_start();
      measure(vecs[i].t_done + 10, t_done, n_samp, n_comp, n_logi, n_busy, first_bit);
      check($sformatf("v%0d_done_cycle", i), t_done,    vecs[i].t_done);
      check($sformatf("v%0d_samp", i),       n_samp,    vecs[i].n_samp);
      check($sformatf("v%0d_comp", i),       n_comp,    vecs[i].n_comp);
      check($sformatf("v%0d_logi", i),       n_logi,    vecs[i].n_logi);
      check($sformatf("v%0d_busy", i),       n_busy,    vecs[i].n_busy);
      check($sformatf("v%0d_first_bit", i),  first_bit, vecs[i].first_bit);
      repeat (2) @(negedge clk);
    end

    run_basic("start_while_busy", 1'b1);

    // continuous mode with a mid-conversion config change
    cfg_samp_len = 8'd1;
    cfg_comp_len = 8'd1;
    cfg_nbits    = 4'd2;
    cont         = 1'b1;
    imask = 32'd0;
    dmask = 32'd0;
    pulse_start();
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (seq_init) imask[c] = 1'b1;
      if (done) dmask[c] = 1'b1;
      if (c == 10) cfg_nbits = 4'd1;
      if (c == 22) cont = 1'b0;
    end
    check("cont_init_cycles", int'(imask), int'(32'h0010_8102));
    check("cont_done_cycles", int'(dmask), int'(32'h0108_4080));

    // abort during the second compare
    set_basic();
    pulse_start();
    for (int c = 1; c <= 8; c++) @(negedge clk);
    check("abort_pre_comp", int'(seq_comp), 1);
    check("abort_pre_bit", int'(bit_idx), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outs", int'(outs_now()), 0);
    check("abort_bit_idx", int'(bit_idx), 0);
    seen = 0;
    for (int c = 10; c <= 25; c++) begin
      @(negedge clk);
      if (busy || done || seq_init) seen++;
    end
    check("abort_quiet", seen, 0);
    run_basic("post_abort", 1'b0);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (busy || seq_init || done) seen++;
      @(negedge clk);
    end
    check("abort_start_idle", seen, 0);

    // async reset between edges during sampling
    set_basic();
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_samp", int'(seq_samp), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", int'(outs_now()), 0);
    check("async_rst_bit", int'(bit_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy || seq_init || seq_samp || seq_comp || seq_logi || done) seen++;
    end
    check("post_rst_quiet", seen, 0);
    run_basic("post_reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sar_seqgen.md
Name: sar_seqgen

Overview:
Conversion timing sequencer for the SAR ADC channel. Turns one start trigger into a registered sequence of phase strobes: init, sample, then N × (compare, logic). Its seq_samp output is the timing source for the downstream sampling-switch control stage. All phase lengths are programmable and latched per conversion.

Parameters:
CNT_W, 8, width of phase-length fields and internal phase counter
BIT_W, 4, width of bit-count field and bit index
MAX_BITS, 12, upper clamp for cfg_nbits

Ports:
clk  in  1  sequencer clock
rst_n  in  1  asynchronous active-low reset
start  in  1  conversion request; sampled on rising clk edge
abort  in  1  synchronous abort; highest priority after reset
cont  in  1  continuous mode; re-arm after done without start
cfg_samp_len  in  CNT_W  sample phase length in cycles (0 treated as 1)
cfg_comp_len  in  CNT_W  compare phase length in cycles (0 treated as 1)
cfg_nbits  in  BIT_W  comparisons per conversion (0 treated as 1; >MAX_BITS clamped)
seq_init  out  1  one-cycle init strobe at conversion start
seq_samp  out  1  sample phase active
seq_comp  out  1  comparator phase active
seq_logi  out  1  one-cycle SAR logic update strobe after each compare
bit_idx  out  BIT_W  current bit, counts down from nbits-1 to 0 during comp/logi
busy  out  1  high from INIT through LOGI of the last bit
done  out  1  one-cycle pulse after the last LOGI

Behaviour:
- All outputs registered. Reset: all outputs 0, bit_idx 0, state IDLE, latched config 0.
- Config latched on the IDLE->INIT transition only. Changes mid-conversion have no effect until the next conversion.
- States: IDLE, INIT, SAMP, COMP, LOGI, DONE.
- IDLE: start=1 at edge k -> INIT. seq_init=1 and busy=1 in cycle k+1 (latency 1).
- INIT: 1 cycle -> SAMP. Phase counter loaded with samp_len-1.
- SAMP: seq_samp=1 for exactly max(samp_len,1) cycles -> COMP. bit_idx=nbits-1.
- COMP: seq_comp=1 for exactly max(comp_len,1) cycles -> LOGI.
- LOGI: seq_logi=1 for 1 cycle.
  - If bit_idx>0: decrement bit_idx, -> COMP.
  - Else -> DONE.
- DONE: done=1, busy=0 for 1 cycle. Then -> INIT if cont=1, else IDLE.
  - With cont=1, re-latch config at DONE->INIT.
  - start during DONE with cont=0 -> INIT (back-to-back).
- Phase outputs seq_init/samp/comp/logi are mutually exclusive (one-hot or all zero) every cycle.
- start while busy: ignored. No queueing.
- abort=1 at any edge in a non-IDLE state:
  - next cycle IDLE, all strobes 0, busy 0, done 0 (no done pulse).
  - abort and start in the same IDLE cycle: abort wins, stay IDLE.
- Async reset mid-conversion: immediate return to reset values, independent of clk.
- Total conversion cycles, INIT through DONE: 1 + S + N×(C+1) + 1, with S, C, N the effective values.
- Counter arithmetic is unsigned CNT_W. A length of 2^CNT_W-1 must not wrap early.

Decomposition:
- Shared package sar_pkg holds:
  - state enum (IDLE, INIT, SAMP, COMP, LOGI, DONE);
  - default CNT_W/BIT_W/MAX_BITS constants;
  - a phase-vector typedef {init, samp, comp, logi}.
- One natural sub-module, sar_phase_cnt: loadable down-counter with a zero flag, reused for sample and compare phases.
- FSM and bit counter stay in the top module.

Test Plan:
- Basic conversion: reset, samp_len=3, comp_len=2, nbits=4, pulse start.
  - Required: init at cycle 1, samp high cycles 2-4.
  - Four comp(2)/logi(1) groups with bit_idx 3,2,1,0.
  - done in cycle 17; busy high cycles 1-16.
- Zero lengths: samp_len=0, comp_len=0, nbits=0.
  - Required: init, 1-cycle samp, 1-cycle comp, 1 logi with bit_idx 0, done; 5 cycles total.
- Continuous mode: cont=1, samp_len=1, comp_len=1, nbits=2.
  - Required: done followed directly by init, repeating with period 7.
  - Config change mid-conversion applies only after the next done.
- Abort: abort asserted during the 2nd COMP of the basic case.
  - Required: next cycle all outputs 0, no done pulse, IDLE.
  - A new start then produces the full basic sequence.
- Start while busy: start pulses during SAMP and LOGI are ignored; timing is identical to the basic case.
- Async reset: rst_n low mid-SAMP between clock edges.
  - Required: outputs clear immediately; after release, no activity until start.
- Checks in all tests:
  - assertion that the phase strobes are one-hot-or-zero every cycle;
  - nbits=15 is clamped to 12 comparisons.
